uart_byte_rx: RTL

UART_BYTE_RX -- requirements
Module: uart_byte_rx

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_rx_sync.sv | 16 +
 rtl/uart_byte_rx.sv | 109 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding, divisor floor and divisor clamp helper.
package uart_pkg;
  localparam int MIN_DIV_DEF = 4;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT} state_t;
  function automatic logic [15:0] eff_div(input logic [15:0] div, input logic [15:0] min_div);
    return (div < min_div) ? min_div : div;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: multi-flop synchronizer for an asynchronous serial input.
module uart_rx_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) sync_q <= {STAGES{RST_VAL}};
    else        sync_q <= {sync_q[STAGES-2:0], d_i};
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART byte receiver with valid/ready output, frame error and overrun pulses.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_DIV     = MIN_DIV_DEF
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        uart_rx_i,
  input  logic [15:0] baud_div_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        frame_err_o,
  output logic        overrun_o
);
  logic        rx_s;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, div_q, div_d, lim;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d, data_q, data_d;
  logic        prev_q, valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic        tick, done, load;

  uart_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
    .clk_i(clk_i),
    .rst_n(rst_n),
    .d_i  (uart_rx_i),
    .q_o  (rx_s)
  );

  // START waits half a bit so every later sample lands mid-bit
  assign lim  = (state_q == S_START) ? (div_q >> 1) - 16'd1 : div_q - 16'd1;
  assign tick = cnt_q == lim;
  assign done = state_q == S_STOP && tick && rx_s;
  assign load = done && (!valid_q || rx_ready_i);

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? 16'd0 : cnt_q + 16'd1;
    div_d   = div_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
        if (prev_q && !rx_s) begin
          state_d = S_START;
          div_d   = eff_div(baud_div_i, 16'(MIN_DIV));
        end
      end
      S_START: if (tick) begin
        state_d = rx_s ? S_IDLE : S_DATA;
        idx_d   = 3'd0;
      end
      S_DATA: if (tick) begin
        sh_d  = {rx_s, sh_q[7:1]};
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = S_STOP;
      end
      S_STOP: if (tick) begin
        state_d = rx_s ? S_IDLE : S_WAIT;
        ferr_d  = !rx_s;
      end
      S_WAIT: begin
        cnt_d = 16'd0;
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // a completed frame always leaves valid high: either freshly loaded or kept on overrun
  assign valid_d = done || (valid_q && !rx_ready_i);
  assign data_d  = load ? sh_q : data_q;
  assign ovr_d   = done && valid_q && !rx_ready_i;

  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      div_q   <= 16'(MIN_DIV);
      idx_q   <= 3'd0;
      sh_q    <= 8'h00;
      data_q  <= 8'h00;
      prev_q  <= 1'b1;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      prev_q  <= rx_s;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end

  assign rx_data_o   = data_q;
  assign rx_valid_o  = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
endmodule
